// File: rtl/integer_square.sv
// integer_square: multi-cycle shift-add squarer, d = q*q + r.
// Rebuilds the radicand from a (root, remainder) pair produced by integer_sqrt.
// Uses the same stall/ready handshake as integer_sqrt. Flags non-canonical
// pairs (r > 2q) and results that do not fit in WIDTH bits.
module integer_square #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             overflow,
    output logic             invalid
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned BITS = HALF / CYCLES;
    localparam int unsigned CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int unsigned AW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    r_mcand;
    logic [HALF-1:0]  r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_ready;
    logic             r_ovf;
    logic             r_inv;
    logic [AW-1:0]    w_partial;
    logic [AW-1:0]    w_sum;
    logic             w_last;

    assign d        = r_d;
    assign ready    = r_ready;
    assign overflow = r_ovf;
    assign invalid  = r_inv;

    assign w_last = (r_cnt == CW'(CYCLES - 1));
    assign w_sum  = r_acc + AW'(r_r);

    // Partial product for this iteration: BITS multiplier bits against the shifted multiplicand.
    always_comb begin
        w_partial = '0;
        for (int unsigned j = 0; j < BITS; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stall forces IDLE from any state.
    always_comb begin
        w_next = r_state;
        if (stall) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_BUSY;
                S_BUSY:  w_next = w_last ? S_FINAL : S_BUSY;
                S_FINAL: w_next = S_DONE;
                S_DONE:  w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath and output registers; outputs hold their values except in FINAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            r_r      <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_ready  <= 1'b0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
        end else if (stall) begin
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_q      <= q;
                    r_r      <= r;
                    r_acc    <= '0;
                    r_mcand  <= AW'(q[HALF-1:0]);
                    r_mplier <= q[HALF-1:0];
                    r_cnt    <= '0;
                end
                S_BUSY: begin
                    r_acc    <= r_acc + w_partial;
                    r_mcand  <= r_mcand << BITS;
                    r_mplier <= r_mplier >> BITS;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_FINAL: begin
                    r_d     <= w_sum[WIDTH-1:0];
                    r_ovf   <= (|r_q[WIDTH-1:HALF]) | (|w_sum[AW-1:WIDTH]);
                    r_inv   <= {1'b0, r_r} > {r_q, 1'b0};
                    r_ready <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_integer_square.sv
// tb_integer_square: scoreboard bench for integer_square at default parameters.
module tb_integer_square;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned CYCLES = 32;
    localparam int          LAT    = CYCLES + 1;

    typedef struct {
        logic [63:0] d;
        logic        ovf;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] d;
    logic        ready;
    logic        overflow;
    logic        invalid;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] last_d  = '0;

    integer_square #(.WIDTH(WIDTH), .CYCLES(CYCLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .q        (q),
        .r        (r),
        .d        (d),
        .ready    (ready),
        .overflow (overflow),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference integer square root (bit-by-bit).
    function automatic void isqrt(input logic [63:0] x, output logic [63:0] root, output logic [63:0] rem);
        logic [63:0] num;
        logic [63:0] res;
        logic [63:0] b;
        num = x;
        res = '0;
        b   = 64'h4000_0000_0000_0000;
        while (b > num) b = b >> 2;
        while (b != 0) begin
            if (num >= res + b) begin
                num = num - (res + b);
                res = (res >> 1) + b;
            end else begin
                res = res >> 1;
            end
            b = b >> 2;
        end
        root = res;
        rem  = num;
    endfunction

    // Force IDLE for a cycle, present operands; the next rising edge is E0.
    task automatic start_op(input logic [63:0] qv, input logic [63:0] rv);
        @(negedge clk);
        stall = 1'b1;
        q = qv;
        r = rv;
        @(negedge clk);
        stall = 1'b0;
    endtask

    // Returns the number of edges after E0 at which ready was first seen, or -1.
    task automatic wait_ready(output int n);
        n = -1;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (ready) begin
                n = k;
                return;
            end
        end
    endtask

    // Full operation: push expectation, run, check latency, pop and compare.
    task automatic run_op(input string tag, input logic [63:0] qv, input logic [63:0] rv,
                          input logic [63:0] ed, input logic eo, input logic ei);
        exp_t e;
        exp_t got;
        int   n;
        start_op(qv, rv);
        e.d = ed; e.ovf = eo; e.inv = ei;
        sb.push_back(e);
        wait_ready(n);
        chk({tag, "_lat"}, 64'(n), 64'(LAT));
        if (n >= 0) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
                got = sb.pop_front();
                chk({tag, "_d"},   d,               got.d);
                chk({tag, "_ovf"}, 64'(overflow),   64'(got.ovf));
                chk({tag, "_inv"}, 64'(invalid),    64'(got.inv));
                last_d = got.d;
            end
        end
    endtask

    // Start an operation and raise stall so that it is sampled at edge E<at>.
    task automatic abort_op(input string tag, input logic [63:0] qv, input logic [63:0] rv, input int at);
        logic seen;
        seen = 1'b0;
        start_op(qv, rv);
        for (int k = 0; k < at; k++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        stall = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        chk({tag, "_ready"}, 64'(seen), 64'd0);
        chk({tag, "_d"},     d,         last_d);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] x;
        logic [63:0] rq;
        logic [63:0] rr;
        logic        held_ok;

        rst_n = 1'b0;
        stall = 1'b1;
        q = '0;
        r = '0;
        repeat (3) @(negedge clk);
        chk("rst_d",     d,              64'd0);
        chk("rst_ready", 64'(ready),     64'd0);
        chk("rst_ovf",   64'(overflow),  64'd0);
        chk("rst_inv",   64'(invalid),   64'd0);
        rst_n = 1'b1;

        // Canonical pair, then outputs must hold while stall stays low.
        run_op("canon", 64'hA000_0000, 64'd1, 64'h6400_0000_0000_0001, 1'b0, 1'b0);
        held_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            q = {$urandom, $urandom};
            r = {$urandom, $urandom};
            if (!ready || d !== 64'h6400_0000_0000_0001) held_ok = 1'b0;
        end
        chk("canon_hold", 64'(held_ok), 64'd1);

        run_op("zero",    64'd0,             64'd0,             64'd0,                   1'b0, 1'b0);
        run_op("maxfit",  64'hFFFF_FFFF,     64'h1_FFFF_FFFE,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op("ovf_inv", 64'hFFFF_FFFF,     64'h1_FFFF_FFFF,   64'd0,                   1'b1, 1'b1);
        run_op("qhigh",   64'h1_0000_0000,   64'd0,             64'd0,                   1'b1, 1'b0);
        run_op("qh_lo",   64'h1_0000_0003,   64'd5,             64'd14,                  1'b1, 1'b0);
        run_op("inv_only",64'd3,             64'd7,             64'd16,                  1'b0, 1'b1);

        // Aborts at E10 and at the FINAL edge: ready never rises, d keeps last result.
        abort_op("abort10", 64'd100, 64'd0, 10);
        run_op("after_abort", 64'd3, 64'd2, 64'd11, 1'b0, 1'b0);
        abort_op("abort_fin", 64'd1000, 64'd0, LAT);
        chk("abort_fin_ovf", 64'(overflow), 64'd0);

        // Asynchronous reset between E5 and E6.
        start_op(64'd77, 64'd1);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_d",     d,             64'd0);
        chk("arst_ready", 64'(ready),    64'd0);
        chk("arst_ovf",   64'(overflow), 64'd0);
        chk("arst_inv",   64'(invalid),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 64'd12345, 64'd100, 64'd152399125, 1'b0, 1'b0);

        // Loopback: sqrt of random radicands must reconstruct exactly.
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            if (i == 0) x = 64'hFFFF_FFFF_FFFF_FFFF;
            if (i == 1) x = 64'd1;
            isqrt(x, rq, rr);
            run_op("loop", rq, rr, x, 1'b0, 1'b0);
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
